// File: rtl/tour_sequencer.sv
// Replays a solved knight's tour as cmd_proc commands: one vertical and one
// horizontal segment per move. UART commands pass through while the tour is idle.
module tour_sequencer #(
  parameter int LAST_MOVE = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic [7:0]  resp,
  output logic        tour_busy
);

  typedef enum logic [2:0] {IDLE, VERT, VWAIT, HORZ, HWAIT} state_t;

  localparam logic [4:0] LAST   = 5'(LAST_MOVE);
  localparam logic [7:0] HEAD_N = 8'h00;
  localparam logic [7:0] HEAD_W = 8'h3F;
  localparam logic [7:0] HEAD_S = 8'h7F;
  localparam logic [7:0] HEAD_E = 8'hBF;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q;
  logic [7:0]  resp_q;
  logic [3:0]  sqV, sqH, squares, opcode;
  logic [7:0]  headV, headH, heading;
  logic        isHorz;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (start_tour) begin idx_d = 5'd0; state_d = VERT; end
      VERT:  if (clr_cmd_rdy) state_d = VWAIT;
      VWAIT: if (send_resp) state_d = HORZ;
      HORZ:  if (clr_cmd_rdy) state_d = HWAIT;
      HWAIT: if (send_resp) begin
        if (idx_q == LAST) state_d = IDLE;
        else begin
          idx_d   = idx_q + 5'd1;
          state_d = VERT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy and resp are registered from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      busy_q  <= 1'b0;
      resp_q  <= 8'h5A;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != IDLE);
      resp_q  <= ((state_d == IDLE) || (state_d == HWAIT && idx_d == LAST)) ? 8'h5A : 8'hA5;
    end
  end

  always_comb begin
    sqV = 4'd0; headV = HEAD_N;
    sqH = 4'd0; headH = HEAD_N;
    case (move)
      8'h01: begin sqV = 4'd2; headV = HEAD_N; sqH = 4'd1; headH = HEAD_E; end
      8'h02: begin sqV = 4'd2; headV = HEAD_N; sqH = 4'd1; headH = HEAD_W; end
      8'h04: begin sqV = 4'd1; headV = HEAD_N; sqH = 4'd2; headH = HEAD_W; end
      8'h08: begin sqV = 4'd1; headV = HEAD_S; sqH = 4'd2; headH = HEAD_W; end
      8'h10: begin sqV = 4'd2; headV = HEAD_S; sqH = 4'd1; headH = HEAD_W; end
      8'h20: begin sqV = 4'd2; headV = HEAD_S; sqH = 4'd1; headH = HEAD_E; end
      8'h40: begin sqV = 4'd1; headV = HEAD_S; sqH = 4'd2; headH = HEAD_E; end
      8'h80: begin sqV = 4'd1; headV = HEAD_N; sqH = 4'd2; headH = HEAD_E; end
      default: ;
    endcase
  end

  always_comb begin
    isHorz  = (state_q == HORZ) || (state_q == HWAIT);
    squares = isHorz ? sqH : sqV;
    heading = isHorz ? headH : headV;
    opcode  = (isHorz && idx_q == LAST) ? 4'b0101 : 4'b0100;
    if (state_q == IDLE) begin
      cmd     = cmd_UART;
      cmd_rdy = cmd_rdy_UART;
    end else begin
      cmd     = {opcode, heading, squares};
      cmd_rdy = (state_q == VERT) || (state_q == HORZ);
    end
  end

  assign mv_indx   = idx_q;
  assign resp      = resp_q;
  assign tour_busy = busy_q;

endmodule

// File: tb/tb_tour_sequencer.sv
// Directed bench for tour_sequencer: a table of move decodes is replayed
// through a scripted cmd_proc, plus hand-written lockout and reset sequences.
module tb_tour_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start_tour, cmd_rdy_UART, clr_cmd_rdy, send_resp;
  logic [7:0]  move, resp;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART, cmd;
  logic        cmd_rdy, tour_busy;

  int errors = 0;
  int checks = 0;
  int cmdCount = 0;
  int a5Count = 0;
  int fiveACount = 0;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] expV;
    logic [15:0] expH;
  } vec_t;

  vec_t table_v[11];

  tour_sequencer #(.LAST_MOVE(23)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd),
    .cmd_rdy(cmd_rdy), .resp(resp), .tour_busy(tour_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Hold the given pulses across one rising edge, then settle 1 time unit past it.
  task automatic applyStimulus(input logic st, input logic clr, input logic snd);
    start_tour  = st;
    clr_cmd_rdy = clr;
    send_resp   = snd;
    @(posedge clk);
    #1;
    start_tour  = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
  endtask

  // One move handled by a well-behaved cmd_proc: VERT -> VWAIT -> HORZ -> HWAIT -> next.
  task automatic runMove(input int idx, input vec_t v, input bit last);
    logic [15:0] expH;
    expH = v.expH;
    if (last) expH[15:12] = 4'b0101;
    move = v.mv;
    #1;
    checkOutput("mv_indx", 16'(mv_indx), 16'(idx));
    checkOutput("vert_rdy", 16'(cmd_rdy), 16'd1);
    checkOutput("vert_cmd", cmd, v.expV);
    if (cmd_rdy) cmdCount++;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("vwait_rdy", 16'(cmd_rdy), 16'd0);
    checkOutput("vwait_resp", 16'(resp), 16'h00A5);
    if (resp == 8'hA5) a5Count++;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("horz_rdy", 16'(cmd_rdy), 16'd1);
    checkOutput("horz_cmd", cmd, expH);
    if (cmd_rdy) cmdCount++;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("hwait_resp", 16'(resp), last ? 16'h005A : 16'h00A5);
    if (resp == 8'hA5) a5Count++;
    if (resp == 8'h5A) fiveACount++;
    applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    table_v[0]  = '{8'h01, 16'h4002, 16'h4BF1};
    table_v[1]  = '{8'h02, 16'h4002, 16'h43F1};
    table_v[2]  = '{8'h04, 16'h4001, 16'h43F2};
    table_v[3]  = '{8'h08, 16'h47F1, 16'h43F2};
    table_v[4]  = '{8'h10, 16'h47F2, 16'h43F1};
    table_v[5]  = '{8'h20, 16'h47F2, 16'h4BF1};
    table_v[6]  = '{8'h40, 16'h47F1, 16'h4BF2};
    table_v[7]  = '{8'h80, 16'h4001, 16'h4BF2};
    table_v[8]  = '{8'h00, 16'h4000, 16'h4000};
    table_v[9]  = '{8'h03, 16'h4000, 16'h4000};
    table_v[10] = '{8'hFF, 16'h4000, 16'h4000};

    rst_n = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    move = 8'h00; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    checkOutput("reset_busy", 16'(tour_busy), 16'd0);
    checkOutput("reset_idx", 16'(mv_indx), 16'd0);
    checkOutput("reset_resp", 16'(resp), 16'h005A);

    cmd_UART = 16'h2000; cmd_rdy_UART = 1'b1;
    #1;
    checkOutput("pass_cmd", cmd, 16'h2000);
    checkOutput("pass_rdy", 16'(cmd_rdy), 16'd1);
    checkOutput("pass_resp", 16'(resp), 16'h005A);
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
    #1;
    checkOutput("pass_cmd2", cmd, 16'h1234);
    checkOutput("pass_rdy2", 16'(cmd_rdy), 16'd0);

    // Full tour; move 23 uses 8'h40 so the fanfare segment is 16'h5BF2.
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++)
      runMove(i, table_v[(i == 23) ? 6 : (i % 11)], i == 23);
    checkOutput("tour_done_busy", 16'(tour_busy), 16'd0);
    checkOutput("tour_done_idx", 16'(mv_indx), 16'd23);
    checkOutput("cmd_count", 16'(cmdCount), 16'd48);
    checkOutput("a5_count", 16'(a5Count), 16'd47);
    checkOutput("5a_count", 16'(fiveACount), 16'd1);

    // Lockout and ordering corner cases on a second tour.
    cmd_rdy_UART = 1'b1; cmd_UART = 16'h2000; move = 8'h01;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t2_idx0", 16'(mv_indx), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("lone_send_vert", 16'(cmd_rdy), 16'd1);
    checkOutput("lone_send_cmd", cmd, 16'h4002);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("clr_send_vwait", 16'(cmd_rdy), 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("lockout_rdy", 16'(cmd_rdy), 16'd0);
    checkOutput("lockout_cmd", 16'(cmd != 16'h2000), 16'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("horz_cmd_t2", cmd, 16'h4BF1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_in_horz_idx", 16'(mv_indx), 16'd0);
    checkOutput("start_in_horz_rdy", 16'(cmd_rdy), 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 7; i++) runMove(i, table_v[i], 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_idx", 16'(mv_indx), 16'd7);
    checkOutput("pre_reset_rdy", 16'(cmd_rdy), 16'd0);

    // Reset low between edges must not disturb state until the next edge.
    rst_n = 1'b0;
    #2;
    checkOutput("sync_reset_hold", 16'(tour_busy), 16'd1);
    checkOutput("sync_reset_idx", 16'(mv_indx), 16'd7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_reset_busy", 16'(tour_busy), 16'd0);
    checkOutput("mid_reset_idx", 16'(mv_indx), 16'd0);
    checkOutput("mid_reset_resp", 16'(resp), 16'h005A);
    checkOutput("mid_reset_cmd", cmd, 16'h2000);
    checkOutput("mid_reset_rdy", 16'(cmd_rdy), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tour_sequencer.md
TOUR_SEQUENCER -- requirements
Module: tour_sequencer

Interface
REQ-001 SHALL have parameter LAST_MOVE, default 23, the index of the final move in the solved tour (24 moves total).
REQ-002 SHALL have ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- start_tour  in  1  one-cycle pulse from the tour solver: solution ready
- move  in  8  one-hot move read from the solver memory at mv_indx
- mv_indx  out  5  move index presented to the solver memory
- cmd_UART  in  16  command from the BLE/UART wrapper
- cmd_rdy_UART  in  1  UART command valid (level)
- clr_cmd_rdy  in  1  pulse from cmd_proc: command consumed
- send_resp  in  1  pulse from cmd_proc: command execution complete
- cmd  out  16  command presented to cmd_proc
- cmd_rdy  out  1  command valid to cmd_proc (level)
- resp  out  8  response byte to the UART wrapper
- tour_busy  out  1  high while the sequencer owns the cmd_proc path

Function
REQ-003 SHALL use states IDLE, VERT, VWAIT, HORZ, HWAIT.
REQ-004 In IDLE, cmd SHALL equal cmd_UART and cmd_rdy SHALL equal cmd_rdy_UART (combinational pass-through).
REQ-005 In IDLE, start_tour SHALL clear mv_indx to 0 and move to VERT on the next edge.
REQ-006 In VERT and HORZ, cmd_rdy SHALL be 1 and cmd SHALL be {opcode[15:12], heading[11:4], squares[3:0]}, built from move.
REQ-007 The opcode SHALL be 4'b0100 (move) for every segment except the HORZ segment of move LAST_MOVE, which SHALL use 4'b0101 (move with fanfare).
REQ-008 Headings: north 8'h00, west 8'h3F, south 8'h7F, east 8'hBF.
REQ-009 Vertical segment (dy, heading) per move bit: b0 (+2, N), b1 (+2, N), b2 (+1, N), b3 (-1, S), b4 (-2, S), b5 (-2, S), b6 (-1, S), b7 (+1, N).
REQ-010 Horizontal segment (dx, heading) per move bit: b0 (+1, E), b1 (-1, W), b2 (-2, W), b3 (-2, W), b4 (-1, W), b5 (+1, E), b6 (+2, E), b7 (+2, E).
REQ-011 squares SHALL be |dy| or |dx| as a 4-bit unsigned value.
REQ-012 A move value that is not exactly one-hot SHALL produce squares=0 and heading north; the sequence SHALL still advance.
REQ-013 A clr_cmd_rdy in VERT SHALL go to VWAIT; a clr_cmd_rdy in HORZ SHALL go to HWAIT. cmd_rdy SHALL be 0 in both wait states.
REQ-014 A send_resp in VWAIT SHALL go to HORZ.
REQ-015 A send_resp in HWAIT SHALL:
- when mv_indx == LAST_MOVE, go to IDLE;
- otherwise increment mv_indx by 1 and go to VERT.
REQ-016 mv_indx SHALL change only on start_tour in IDLE or on a send_resp in HWAIT.
REQ-017 resp SHALL be 8'hA5 while tour_busy, except 8'h5A in HWAIT when mv_indx == LAST_MOVE.
REQ-018 resp SHALL be 8'h5A in IDLE.
REQ-019 tour_busy SHALL be 1 in every state except IDLE.
REQ-020 While tour_busy, cmd_rdy_UART SHALL be ignored and never forwarded; UART commands SHALL NOT be queued.
REQ-021 start_tour outside IDLE SHALL be ignored.
REQ-022 In VERT/HORZ, a clr_cmd_rdy and send_resp in the same cycle SHALL follow clr_cmd_rdy only; a send_resp that arrives alone SHALL be ignored.
REQ-023 Transitions SHALL take effect on the edge after the causing input; there SHALL be no multi-cycle latency beyond this.

Reset
REQ-024 When rst_n=0 at a clock edge, the block SHALL enter IDLE with mv_indx=0, tour_busy=0, and registered outputs cleared, with resp=8'h5A and cmd/cmd_rdy following the UART pass-through. This SHALL hold even mid-tour.
REQ-025 Reset SHALL be synchronous only; rst_n SHALL have no effect between clock edges.

Verification
REQ-026 Pass-through: in IDLE, cmd_UART=16'h2000, cmd_rdy_UART=1 -> cmd=16'h2000, cmd_rdy=1 in the same cycle, resp=8'h5A.
REQ-027 Single move: start_tour, then move=8'h01 -> cmd=16'h4002 (N, 2 squares); clr_cmd_rdy then send_resp -> resp=8'hA5 and cmd=16'h4BF1 (E, 1 square).
REQ-028 Last move: mv_indx=23, move=8'h40 -> VERT cmd=16'h47F1, then HORZ cmd=16'h5BF2; in HWAIT resp=8'h5A; send_resp -> IDLE, tour_busy=0.
REQ-029 Full tour: 24 moves with a scripted cmd_proc model -> exactly 48 commands; 47 segment completions report A5 and the last reports 5A; mv_indx steps 0..23.
REQ-030 Lockout: cmd_rdy_UART=1 during VWAIT -> cmd_rdy stays 0; start_tour during HORZ -> mv_indx unchanged.
REQ-031 Reset mid-tour: rst_n=0 for one edge during HWAIT at mv_indx=7 -> IDLE, mv_indx=0, tour_busy=0 on that edge.
